cj_cosim_checker: RTL and testbench
===================================

# cj_cosim_checker

Lock-step co-simulation checker beside the SoC test harness. Compares each instruction the core commits against a golden-model commit stream, snoops memory writes to the `tohost` mailbox, and drives the 64-bit `tohost` word the testbench polls for end-of-test. Testbench `tohost[0]`=1 means the round is finished. The value in `tohost` is either the program's exit code or a checker error code.

## Interface
Parameters:
- XLEN, 64, datapath width of pc, data and tohost.
- TOHOST_ADDR, 64'h8000_1000, byte address of the mailbox doubleword.
- REF_DEPTH, 8, golden-entry FIFO depth; must be a power of 2 and at least 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- ref_valid  in  1  golden-model commit entry offered.
- ref_ready  out  1  FIFO can accept an entry; equals !full.
- ref_pc  in  XLEN  golden pc.
- ref_wdata  in  XLEN  golden register write-back value.
- dut_commit_valid  in  1  core retired one instruction this cycle.
- dut_commit_pc  in  XLEN  retired pc.
- dut_commit_wdata  in  XLEN  retired write-back value.
- mem_wr_valid  in  1  memory write beat.
- mem_wr_addr  in  XLEN  byte address of the beat, doubleword aligned.
- mem_wr_data  in  XLEN  write data.
- mem_wr_strb  in  XLEN/8  byte enables.
- host_set_valid  in  1  host forces the tohost value (timeout path).
- host_set_value  in  XLEN  value to force.
- tohost  out  XLEN  mailbox word.
- mismatch  out  1  sticky; set on any checker error.
- commit_count  out  XLEN  number of matched commits.

## Operation
- Golden FIFO:
  - An entry is enqueued when ref_valid && ref_ready.
  - The head entry is dequeued on every dut_commit_valid while the FIFO is non-empty.
  - If the FIFO is full and a commit arrives in the same cycle, enqueue still waits: ref_ready is computed from the pre-dequeue state.
- Commit compare, performed on dut_commit_valid:
  - FIFO empty: underflow error, code 4, no pop.
  - pc differs from the head entry: error code 1.
  - pc matches but wdata differs: error code 3.
  - Both match: commit_count increments by 1 and wraps modulo 2^XLEN.
- An error with code c loads tohost <= (c<<1)|1, giving pc mismatch = 3, wdata mismatch = 7, underflow = 9. The error also sets mismatch.
- Mailbox write: when mem_wr_valid and mem_wr_addr == TOHOST_ADDR, the enabled bytes of mem_wr_data are merged into tohost.
- Host set: host_set_valid loads tohost <= host_set_value. The testbench uses 5 for timeout.
- Finished state: once tohost[0] is 1, the value is frozen.
  - Mailbox writes and checker errors no longer change tohost.
  - host_set still overrides.
  - Compares, mismatch and commit_count keep updating.
- Same-cycle priority for tohost: host_set > commit error > mailbox write.
- Commit compare and mailbox write are independent. Only their effect on tohost is prioritised.

## Timing
- Reset (reset==0 at a rising edge):
  - tohost=0, mismatch=0, commit_count=0.
  - FIFO is emptied, so ref_ready=1 in the following cycle.
- Reset mid-run discards all queued entries.
- All outputs are registered. tohost, mismatch and commit_count reflect an event one cycle after the edge that samples it.
- ref_ready is combinational from the registered FIFO state, with no input-to-output path.
- No bypass: an entry enqueued in cycle N is comparable no earlier than cycle N+1. A commit in the same cycle as an enqueue into an empty FIFO is an underflow.
- Sustained throughput is one enqueue plus one commit per cycle.
- FIFO pointers wrap modulo REF_DEPTH. Full and empty are distinguished by an extra pointer bit.

## Test plan
- Reset, then enqueue 3 golden entries (pc 0x80000000/4/8); commit 3 matching instructions → commit_count=3, mismatch=0, tohost=0.
- One golden entry pc 0x80000000, commit pc 0x80000004 → next cycle tohost=3, mismatch=1. A later mailbox write of 1 leaves tohost at 3.
- Matching pc with wdata 0x5 vs golden 0x6 → tohost=7. Commit with FIFO empty → tohost=9 and no pop.
- Write 0x1 with strb 0xFF to TOHOST_ADDR → tohost=1. A write to TOHOST_ADDR+8 has no effect.
- Fill the FIFO to REF_DEPTH → ref_ready=0; enqueue and commit in the same cycle → only the pop happens, and ref_ready=1 the next cycle.
- host_set_valid with 5 in the same cycle as a pc mismatch and a mailbox write → tohost=5. A reset pulse afterwards → tohost=0, commit_count=0, FIFO empty.

Source files
------------

// File: rtl/cj_cosim_checker.sv
// Lock-step commit checker: compares core retirements against a golden
// commit FIFO and maintains the tohost mailbox word polled for end-of-test.
module cj_cosim_checker #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 64'h8000_1000,
  parameter int              REF_DEPTH   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ref_valid,
  output logic              ref_ready,
  input  logic [XLEN-1:0]   ref_pc,
  input  logic [XLEN-1:0]   ref_wdata,
  input  logic              dut_commit_valid,
  input  logic [XLEN-1:0]   dut_commit_pc,
  input  logic [XLEN-1:0]   dut_commit_wdata,
  input  logic              mem_wr_valid,
  input  logic [XLEN-1:0]   mem_wr_addr,
  input  logic [XLEN-1:0]   mem_wr_data,
  input  logic [XLEN/8-1:0] mem_wr_strb,
  input  logic              host_set_valid,
  input  logic [XLEN-1:0]   host_set_value,
  output logic [XLEN-1:0]   tohost,
  output logic              mismatch,
  output logic [XLEN-1:0]   commit_count
);

  localparam int AW = $clog2(REF_DEPTH);
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] r_pc_mem [REF_DEPTH];
  logic [XLEN-1:0] r_wd_mem [REF_DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_head_pc;
  logic [XLEN-1:0] w_head_wd;
  logic [2:0]      w_code;
  logic            w_match;
  logic            w_mbox;
  logic [XLEN-1:0] w_merged;
  logic [XLEN-1:0] w_err_val;

  // Extra pointer bit separates full from empty when low bits coincide.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign ref_ready = !w_full;
  assign w_push    = ref_valid && !w_full;
  assign w_pop     = dut_commit_valid && !w_empty;

  assign w_head_pc = r_pc_mem[r_rptr[AW-1:0]];
  assign w_head_wd = r_wd_mem[r_rptr[AW-1:0]];

  always_comb begin
    w_code  = 3'd0;
    w_match = 1'b0;
    if (dut_commit_valid) begin
      if (w_empty)
        w_code = 3'd4;
      else if (dut_commit_pc != w_head_pc)
        w_code = 3'd1;
      else if (dut_commit_wdata != w_head_wd)
        w_code = 3'd3;
      else
        w_match = 1'b1;
    end
  end

  assign w_err_val = {{(XLEN-4){1'b0}}, w_code, 1'b1};
  assign w_mbox    = mem_wr_valid && (mem_wr_addr == TOHOST_ADDR);

  always_comb begin
    w_merged = tohost;
    for (int i = 0; i < NB; i++)
      if (mem_wr_strb[i])
        w_merged[8*i +: 8] = mem_wr_data[8*i +: 8];
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc_mem[r_wptr[AW-1:0]] <= ref_pc;
      r_wd_mem[r_wptr[AW-1:0]] <= ref_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      tohost       <= '0;
      mismatch     <= 1'b0;
      commit_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_match)
        commit_count <= commit_count + 1'b1;
      if (w_code != 3'd0)
        mismatch <= 1'b1;
      // Once bit 0 is set the word is frozen except for host overrides.
      if (host_set_valid)
        tohost <= host_set_value;
      else if (!tohost[0]) begin
        if (w_code != 3'd0)
          tohost <= w_err_val;
        else if (w_mbox)
          tohost <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_cj_cosim_checker.sv
// Randomized bench for cj_cosim_checker against a queue-based
// reference model of the commit checker and tohost mailbox.
module tb_cj_cosim_checker;

  localparam int          DEPTH = 8;
  localparam logic [63:0] TADDR = 64'h8000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        ref_valid;
  logic        ref_ready;
  logic [63:0] ref_pc;
  logic [63:0] ref_wdata;
  logic        dut_commit_valid;
  logic [63:0] dut_commit_pc;
  logic [63:0] dut_commit_wdata;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_strb;
  logic        host_set_valid;
  logic [63:0] host_set_value;
  logic [63:0] tohost;
  logic        mismatch;
  logic [63:0] commit_count;

  always #5 clock = ~clock;

  cj_cosim_checker #(
    .XLEN(64), .TOHOST_ADDR(TADDR), .REF_DEPTH(DEPTH)
  ) u_dut (
    .clock(clock), .reset(reset),
    .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_pc(ref_pc), .ref_wdata(ref_wdata),
    .dut_commit_valid(dut_commit_valid),
    .dut_commit_pc(dut_commit_pc),
    .dut_commit_wdata(dut_commit_wdata),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
    .host_set_valid(host_set_valid),
    .host_set_value(host_set_value),
    .tohost(tohost), .mismatch(mismatch),
    .commit_count(commit_count)
  );

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [63:0] rpc, rwd;
    logic        cv;
    logic [63:0] cpc, cwd;
    logic        mv;
    logic [63:0] ma, md;
    logic [7:0]  ms;
    logic        hv;
    logic [63:0] hval;
  } stim_t;

  int checks = 0;
  int errors = 0;

  logic [63:0] qpc[$];
  logic [63:0] qwd[$];
  logic [63:0] m_tohost;
  logic        m_mis;
  logic [63:0] m_cnt;

  stim_t s;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t t;
    t = '{default: '0};
    t.rst_n = 1'b1;
    return t;
  endfunction

  task automatic model(input stim_t t);
    int          code;
    bit          ready;
    logic [63:0] v;
    ready = qpc.size() < DEPTH;
    if (!t.rst_n) begin
      qpc.delete(); qwd.delete();
      m_tohost = 0; m_mis = 0; m_cnt = 0;
      return;
    end
    code = 0;
    if (t.cv) begin
      if (qpc.size() == 0) code = 4;
      else begin
        if (t.cpc != qpc[0]) code = 1;
        else if (t.cwd != qwd[0]) code = 3;
        else m_cnt = m_cnt + 1;
        void'(qpc.pop_front());
        void'(qwd.pop_front());
      end
    end
    if (t.rv && ready) begin
      qpc.push_back(t.rpc);
      qwd.push_back(t.rwd);
    end
    if (code != 0) m_mis = 1;
    if (t.hv) m_tohost = t.hval;
    else if (!m_tohost[0]) begin
      if (code != 0) m_tohost = 64'(code * 2 + 1);
      else if (t.mv && t.ma == TADDR) begin
        v = m_tohost;
        for (int i = 0; i < 8; i++)
          if (t.ms[i]) v[8*i +: 8] = t.md[8*i +: 8];
        m_tohost = v;
      end
    end
  endtask

  task automatic step(input stim_t t);
    reset            = t.rst_n;
    ref_valid        = t.rv;
    ref_pc           = t.rpc;
    ref_wdata        = t.rwd;
    dut_commit_valid = t.cv;
    dut_commit_pc    = t.cpc;
    dut_commit_wdata = t.cwd;
    mem_wr_valid     = t.mv;
    mem_wr_addr      = t.ma;
    mem_wr_data      = t.md;
    mem_wr_strb      = t.ms;
    host_set_valid   = t.hv;
    host_set_value   = t.hval;
    #1;
    chk("ref_ready", 64'(ref_ready), 64'(qpc.size() < DEPTH));
    @(posedge clock);
    model(t);
    #1;
    chk("tohost", tohost, m_tohost);
    chk("mismatch", 64'(mismatch), 64'(m_mis));
    chk("commit_count", commit_count, m_cnt);
  endtask

  task automatic push(input logic [63:0] pc, input logic [63:0] wd);
    s = idle(); s.rv = 1; s.rpc = pc; s.rwd = wd; step(s);
  endtask

  task automatic commit(input logic [63:0] pc, input logic [63:0] wd);
    s = idle(); s.cv = 1; s.cpc = pc; s.cwd = wd; step(s);
  endtask

  task automatic hset(input logic [63:0] v);
    s = idle(); s.hv = 1; s.hval = v; step(s);
  endtask

  task automatic mbox(input logic [63:0] a, input logic [63:0] d);
    s = idle(); s.mv = 1; s.ma = a; s.md = d; s.ms = 8'hFF; step(s);
  endtask

  initial begin
    s = idle();
    s.rst_n = 0;
    step(s);
    step(s);
    chk("rst_tohost", tohost, 64'h0);
    chk("rst_cnt", commit_count, 64'h0);
    chk("rst_ready", 64'(ref_ready), 64'h1);

    for (int i = 0; i < 3; i++) push(64'h8000_0000 + 4*i, 64'(i + 10));
    for (int i = 0; i < 3; i++) commit(64'h8000_0000 + 4*i, 64'(i + 10));
    chk("tp1_cnt", commit_count, 64'd3);
    chk("tp1_mis", 64'(mismatch), 64'd0);
    chk("tp1_tohost", tohost, 64'd0);

    push(64'h8000_0000, 64'h1);
    commit(64'h8000_0004, 64'h1);
    chk("tp2_pc", tohost, 64'd3);
    chk("tp2_mis", 64'(mismatch), 64'd1);
    mbox(TADDR, 64'h1);
    chk("tp2_frozen", tohost, 64'd3);

    hset(64'h0);
    push(64'h8000_0010, 64'h6);
    commit(64'h8000_0010, 64'h5);
    chk("tp3_wd", tohost, 64'd7);
    hset(64'h0);
    commit(64'h8000_0000, 64'h0);
    chk("tp3_uf", tohost, 64'd9);
    hset(64'h0);

    mbox(TADDR, 64'h1);
    chk("tp4_mbox", tohost, 64'd1);
    hset(64'h0);
    mbox(TADDR + 64'd8, 64'h1);
    chk("tp4_other", tohost, 64'd0);

    for (int i = 0; i < DEPTH; i++) push(64'h9000_0000 + 4*i, 64'(i));
    chk("tp5_full", 64'(ref_ready), 64'd0);
    s = idle();
    s.rv = 1; s.rpc = 64'hdead; s.rwd = 64'hbeef;
    s.cv = 1; s.cpc = 64'h9000_0000; s.cwd = 64'h0;
    step(s);
    chk("tp5_ready", 64'(ref_ready), 64'd1);
    chk("tp5_depth", 64'(qpc.size()), 64'(DEPTH - 1));

    s = idle();
    s.hv = 1; s.hval = 64'd5;
    s.cv = 1; s.cpc = 64'h1234; s.cwd = 0;
    s.mv = 1; s.ma = TADDR; s.md = 64'h1; s.ms = 8'hFF;
    step(s);
    chk("tp6_host", tohost, 64'd5);
    s = idle(); s.rst_n = 0; step(s);
    chk("tp6_rst_tohost", tohost, 64'd0);
    chk("tp6_rst_cnt", commit_count, 64'd0);
    chk("tp6_rst_ready", 64'(ref_ready), 64'd1);

    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 199) != 0);
      s.rv  = ($urandom_range(0, 2) != 0);
      s.rpc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 15));
      s.rwd = 64'($urandom_range(0, 7));
      s.cv  = ($urandom_range(0, 2) != 0);
      if (qpc.size() > 0 && $urandom_range(0, 4) != 0) begin
        s.cpc = qpc[0];
        s.cwd = ($urandom_range(0, 7) == 0) ? (qwd[0] ^ 64'h1) : qwd[0];
      end else begin
        s.cpc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 15));
        s.cwd = 64'($urandom_range(0, 7));
      end
      s.mv = ($urandom_range(0, 4) == 0);
      s.ma = $urandom_range(0, 1) ? TADDR : TADDR + 64'd8;
      s.md = {$urandom, $urandom};
      s.ms = 8'($urandom);
      s.hv = ($urandom_range(0, 7) == 0);
      s.hval = $urandom_range(0, 2) != 0 ? 64'h0 : {$urandom, $urandom};
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
